// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM state encoding
// and requester count.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // One-hot mask for a requester index, used to exclude the current owner.
    function automatic logic [NUM_REQ-1:0] idx_mask(input logic [1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/arbiter_rr_4_if.sv
// Request/grant bundle between the four requesters and the arbiter.
interface arbiter_rr_4_if;
    import arb_pkg::*;

    logic               en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [1:0]         gnt_idx;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_idx
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_idx
    );

endinterface

// File: rtl/decoder_2_4.sv
// 2-to-4 line decoder with enable; output bit {b,a} is set when en is high.
module decoder_2_4 (
    input  logic       a,
    input  logic       b,
    input  logic       en,
    output logic [3:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[{b, a}] = 1'b1;
        end
    end

endmodule

// File: rtl/arbiter_rr_4.sv
// Four-way round-robin arbiter with hold limit and a one-cycle turnaround gap;
// the registered owner index is expanded to a one-hot grant by decoder_2_4.
module arbiter_rr_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    arbiter_rr_4_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);

    arb_state_t         state, state_n;
    logic [1:0]         idx, idx_n;
    logic [1:0]         last, last_n;
    logic [HOLD_W-1:0]  cnt, cnt_n;
    logic               others_wait;
    logic               gnt_valid;

    // Rotate-priority search: the lowest offset after 'from' with a request wins.
    // Only meaningful when r is non-zero.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                           input logic [1:0]         from);
        logic [1:0] pick;
        logic [1:0] cand;
        pick = from + 2'd1;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = from + 2'(k);
            if (r[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
            last  <= 2'd3;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

    assign others_wait = |(bus.req & ~idx_mask(idx));

    always_comb begin
        state_n = state;
        idx_n   = idx;
        last_n  = last;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.en && (|bus.req)) begin
                    idx_n   = rr_pick(bus.req, last);
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                // Release and preempt both lead to GAP, so their overlap needs no priority.
                if (!bus.req[idx]) begin
                    state_n = GAP;
                end else if ((MAX_HOLD != 0) && (cnt == HOLD_LIM) && others_wait) begin
                    state_n = GAP;
                end
                if (cnt != HOLD_SAT) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                state_n = IDLE;
                last_n  = idx;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign gnt_valid     = (state == GRANT);
    assign bus.gnt_valid = gnt_valid;
    assign bus.gnt_idx   = idx;

    decoder_2_4 u_gnt_dec (
        .a  (idx[0]),
        .b  (idx[1]),
        .en (gnt_valid),
        .y  (bus.gnt)
    );

endmodule

// File: tb/tb_arbiter_rr_4.sv
// Directed bench for arbiter_rr_4 with hand-computed grant sequences.
module tb_arbiter_rr_4;

    logic clk;
    logic rst;
    int   n_asserts;
    int   n_fail;

    arbiter_rr_4_if bus ();

    arbiter_rr_4 #(
        .MAX_HOLD (8),
        .HOLD_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic v, input logic [1:0] i);
        check({tag, ".gnt"}, bus.gnt, g);
        check({tag, ".gnt_valid"}, {3'b000, bus.gnt_valid}, {3'b000, v});
        check({tag, ".gnt_idx"}, {2'b00, bus.gnt_idx}, {2'b00, i});
    endtask

    initial begin
        logic [3:0] exp_g;
        n_asserts = 0;
        n_fail    = 0;

        // Reset with every requester active
        rst     = 1'b1;
        bus.en  = 1'b1;
        bus.req = 4'b1111;
        tick();
        tick();
        check_all("reset", 4'b0000, 1'b0, 2'd0);

        rst = 1'b0;
        tick();
        check_all("first_grant", 4'b0001, 1'b1, 2'd0);

        // Full rotation with preemption after 8 cycles each
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            for (int c = 0; c < 8; c++) begin
                check($sformatf("rr_owner%0d_c%0d", k % 4, c), bus.gnt, exp_g);
                tick();
            end
            check($sformatf("rr_gap%0d_a", k), bus.gnt, 4'b0000);
            tick();
            check($sformatf("rr_gap%0d_b", k), bus.gnt, 4'b0000);
            tick();
        end
        check_all("rr_wrap_next", 4'b0010, 1'b1, 2'd1);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check_all("async_reset_rr", 4'b0000, 1'b0, 2'd0);
        rst = 1'b0;

        // Lone requester is never preempted
        bus.req = 4'b0100;
        tick();
        check_all("single_first", 4'b0100, 1'b1, 2'd2);
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("single_c%0d", c), bus.gnt, 4'b0100);
        end

        // Drop to idle, then get requester 0 as owner
        bus.req = 4'b0000;
        tick();
        check_all("single_release", 4'b0000, 1'b0, 2'd2);
        tick();
        bus.req = 4'b0001;
        tick();
        check_all("owner0", 4'b0001, 1'b1, 2'd0);

        // Owner 0 releases while requester 1 waits
        bus.req = 4'b0011;
        tick();
        check("owner0_hold", bus.gnt, 4'b0001);
        bus.req = 4'b0010;
        tick();
        check_all("drop_gap", 4'b0000, 1'b0, 2'd0);
        tick();
        check("drop_idle", bus.gnt, 4'b0000);
        tick();
        check_all("drop_next", 4'b0010, 1'b1, 2'd1);

        // Enable low blocks grants from IDLE
        bus.req = 4'b0000;
        tick();
        tick();
        bus.en  = 1'b0;
        bus.req = 4'b0011;
        tick();
        check("en_low_a", bus.gnt, 4'b0000);
        tick();
        check("en_low_b", bus.gnt, 4'b0000);
        bus.en = 1'b1;
        tick();
        check_all("en_high", 4'b0001, 1'b1, 2'd0);

        // Enable low during a grant changes nothing
        bus.en = 1'b0;
        tick();
        check("en_low_in_grant", bus.gnt, 4'b0001);

        // Hand over to requester 3, then reset mid-grant
        bus.en  = 1'b1;
        bus.req = 4'b1000;
        tick();
        check("to3_gap", bus.gnt, 4'b0000);
        tick();
        tick();
        check_all("owner3", 4'b1000, 1'b1, 2'd3);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_reset_mid", 4'b0000, 1'b0, 2'd0);
        bus.req = 4'b1001;
        tick();
        check("reset_held", bus.gnt, 4'b0000);
        rst = 1'b0;
        tick();
        check_all("restart_prio0", 4'b0001, 1'b1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/arbiter_rr_4.md
# arbiter_rr_4

Round-robin arbiter that shares one resource among four requesters and drives a registered one-hot grant. The winning 2-bit index is expanded through `decoder_2_4`, so grant encoding matches the decoder's output ordering. It sits between four request sources and the shared datapath, and sequences ownership with a hold limit and a one-cycle turnaround gap.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another requester waits. 0 disables the limit.
- `HOLD_W`, default 4: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  arbitration enable. Low blocks new grants only.
- `req`  in  4  request per requester. Bit i belongs to requester i.
- `gnt`  out  4  one-hot grant. Registered, driven via `decoder_2_4`.
- `gnt_valid`  out  1  high when any grant is active.
- `gnt_idx`  out  2  index of current or last granter.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one owner.
  - GAP: one dead cycle after any grant ends.
- IDLE:
  - If `en`=1 and `req`!=0, pick the winner by round-robin search starting at `last+1` mod 4 (wrap 3->0). Load `gnt_idx`, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - Owner holds while `req[gnt_idx]`=1. The hold counter increments each cycle and saturates at MAX_HOLD.
  - Release: `req[gnt_idx]`=0 -> GAP.
  - Preempt: MAX_HOLD!=0, counter = MAX_HOLD-1, and any other `req` bit is set -> GAP.
  - If no other requester is waiting, the owner keeps the grant indefinitely.
- GAP: unconditionally -> IDLE. `last` <= `gnt_idx`.
- `en`=0 in GRANT has no effect. The grant runs until release or preempt.
- `gnt` = `decoder_2_4(a=gnt_idx[0], b=gnt_idx[1], en=gnt_valid)`. `gnt` is therefore all-zero whenever `gnt_valid`=0.
- Requests that drop while waiting are simply not considered. There is no request latching.
- Only one `gnt` bit is ever high.

## Timing
- Reset values:
  - state = IDLE
  - `gnt_valid` = 0
  - `gnt` = 0000
  - `gnt_idx` = 0
  - `last` = 3, so requester 0 has first priority
  - hold counter = 0
- Assertion of `rst` at any time, including mid-grant, forces the reset values immediately (asynchronously).
- Latency:
  - `req` sampled high in IDLE at edge N -> `gnt` high after edge N.
  - `req` drop sampled at edge N -> `gnt` low after edge N. Next grant appears after edge N+2 at the earliest (GAP, then IDLE decision).
- Preemption: with MAX_HOLD=8, an owner holds for exactly 8 cycles when others are waiting.
- Simultaneous release and preempt condition: treated as release. Both paths go to GAP, so the behaviour is identical.
- Back-to-back ownership: minimum grant period is 1 cycle, minimum gap is 1 cycle, so every handover costs 2 idle cycles.

## Structure
- Shared package `arb_pkg`:
  - state encoding: IDLE=2'd0, GRANT=2'd1, GAP=2'd2
  - `NUM_REQ`=4 constant
- Sub-module: one `decoder_2_4` instance for grant expansion. No other hierarchy.
- Round-robin search is a combinational rotate-priority function inside the block.

## Test plan
- Reset with `req`=1111, then release `rst` -> `gnt`=0001 one cycle later and `gnt_idx`=0.
- `req`=1111 held constant, MAX_HOLD=8 -> grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 cycles, separated by 2 zero cycles.
- Single requester `req`=0100 for 20 cycles -> `gnt`=0100 for all cycles after the first edge, with no preemption.
- Owner 0 drops `req[0]` while `req`=0010 -> `gnt` 0001 -> 0000 for 2 cycles -> 0010.
- `en`=0 with `req`=0011 from IDLE -> `gnt` stays 0000. `en` high -> `gnt`=0001 the next cycle.
- Assert `rst` mid-grant (`gnt`=1000) -> `gnt`=0000 and `gnt_valid`=0 without waiting for a clock edge. After release, priority restarts at requester 0.
